wb_regfile_hilo: RTL and testbench

// - Write-back sink of the MEM->WB pipeline register: commits wb_* results into the 32x32 GPR file and HI/LO pair.
// - Serves ID-stage operand reads (2 GPR ports) and EX-stage HI/LO reads, with same-cycle write-through bypass.
// - Sits at the end of the 5-stage MiniMIPS32 pipeline; consumers are the ID decoder (rs/rt) and EX (MFHI/MFLO).

---
 rtl/wb_regfile_hilo_pkg.sv | 20 ++
 rtl/wb_regfile_hilo_hilo_reg.sv | 53 +++++
 rtl/wb_regfile_hilo.sv | 100 ++++++++++
 tb/tb_wb_regfile_hilo.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/wb_regfile_hilo_pkg.sv
// ----------------------------------------------------------------------------
// wb_regfile_hilo_pkg
// Shared widths and control-level constants for the write-back register file
// slice of the MiniMIPS32 pipeline.
//   REG_BUS_W    : width of a GPR / HI / LO word
//   REG_ADDR_W   : GPR index width (register count = 2**REG_ADDR_W)
//   RST_ENABLE   : level of cpu_rst_n that holds the block in reset
//   WRITE_ENABLE : level of wb_wreg / wb_whilo that commits a write
//   READ_ENABLE  : level of re1 / re2 that enables a read port
// ----------------------------------------------------------------------------
package wb_regfile_hilo_pkg;

    localparam int   REG_BUS_W    = 32;
    localparam int   REG_ADDR_W   = 5;

    localparam logic RST_ENABLE   = 1'b0;
    localparam logic WRITE_ENABLE = 1'b1;
    localparam logic READ_ENABLE  = 1'b1;

endpackage : wb_regfile_hilo_pkg

// File: rtl/wb_regfile_hilo_hilo_reg.sv
// ----------------------------------------------------------------------------
// hilo_reg
// HI/LO register pair written together from the WB stage, with a same-cycle
// bypass so EX-stage MFHI/MFLO see a value being committed in this cycle.
// Ports:
//   cpu_clk_75M  in   pipeline clock (rising edge)
//   cpu_rst_n    in   asynchronous active-low reset
//   wb_whilo     in   write enable for both HI and LO
//   wb_hi/wb_lo  in   HI/LO write data
//   hi_o/lo_o    out  current HI/LO including bypass (combinational)
// ----------------------------------------------------------------------------
module hilo_reg
    import wb_regfile_hilo_pkg::*;
#(
    parameter int DATA_W = REG_BUS_W
) (
    input  logic              cpu_clk_75M,
    input  logic              cpu_rst_n,
    input  logic              wb_whilo,
    input  logic [DATA_W-1:0] wb_hi,
    input  logic [DATA_W-1:0] wb_lo,
    output logic [DATA_W-1:0] hi_o,
    output logic [DATA_W-1:0] lo_o
);

    logic [DATA_W-1:0] hi_q;
    logic [DATA_W-1:0] lo_q;

    always_ff @(posedge cpu_clk_75M or negedge cpu_rst_n) begin
        if (!cpu_rst_n) begin
            hi_q <= '0;
            lo_q <= '0;
        end else if (wb_whilo == WRITE_ENABLE) begin
            hi_q <= wb_hi;
            lo_q <= wb_lo;
        end
    end

    // Reset forces zero even though storage is already cleared, so the
    // outputs do not follow wb_hi/wb_lo while reset is held.
    always_comb begin
        hi_o = hi_q;
        lo_o = lo_q;
        if (cpu_rst_n == RST_ENABLE) begin
            hi_o = '0;
            lo_o = '0;
        end else if (wb_whilo == WRITE_ENABLE) begin
            hi_o = wb_hi;
            lo_o = wb_lo;
        end
    end

endmodule : hilo_reg

// File: rtl/wb_regfile_hilo.sv
// ----------------------------------------------------------------------------
// wb_regfile_hilo
// Write-back sink of the MEM->WB pipeline register. Commits wb_* results into
// the 32x32 GPR file and the HI/LO pair, and serves two ID-stage GPR read
// ports plus the EX-stage HI/LO read, all with same-cycle write-through.
// Ports:
//   cpu_clk_75M        in   pipeline clock (rising edge)
//   cpu_rst_n          in   asynchronous active-low reset
//   wb_wd/wb_wreg      in   GPR write index / enable
//   wb_wdata           in   GPR write data
//   wb_whilo           in   HI/LO write enable (both words)
//   wb_hi/wb_lo        in   HI/LO write data
//   re1/re2            in   read-port enables
//   raddr1/raddr2      in   read indices
//   rdata1/rdata2      out  read data (combinational)
//   hi_o/lo_o          out  current HI/LO including bypass (combinational)
// A bubble (wb_wreg=0, wb_whilo=0) leaves all state untouched; stalls and
// flushes arrive here already converted into bubbles.
// ----------------------------------------------------------------------------
module wb_regfile_hilo
    import wb_regfile_hilo_pkg::*;
#(
    parameter int DATA_W = REG_BUS_W,
    parameter int ADDR_W = REG_ADDR_W
) (
    input  logic              cpu_clk_75M,
    input  logic              cpu_rst_n,
    input  logic [ADDR_W-1:0] wb_wd,
    input  logic              wb_wreg,
    input  logic [DATA_W-1:0] wb_wdata,
    input  logic              wb_whilo,
    input  logic [DATA_W-1:0] wb_hi,
    input  logic [DATA_W-1:0] wb_lo,
    input  logic              re1,
    input  logic [ADDR_W-1:0] raddr1,
    input  logic              re2,
    input  logic [ADDR_W-1:0] raddr2,
    output logic [DATA_W-1:0] rdata1,
    output logic [DATA_W-1:0] rdata2,
    output logic [DATA_W-1:0] hi_o,
    output logic [DATA_W-1:0] lo_o
);

    localparam int NUM_REGS = 2 ** ADDR_W;

    logic [DATA_W-1:0] gpr [0:NUM_REGS-1];

    // $0 is never written, so entry 0 stays at its reset value of zero.
    always_ff @(posedge cpu_clk_75M or negedge cpu_rst_n) begin
        if (!cpu_rst_n) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                gpr[i] <= '0;
            end
        end else if (wb_wreg == WRITE_ENABLE && wb_wd != '0) begin
            gpr[wb_wd] <= wb_wdata;
        end
    end

    // Read port 1: reset, disabled port and $0 all read zero; a write in
    // flight to the same index is forwarded ahead of storage.
    always_comb begin
        rdata1 = gpr[raddr1];
        if (cpu_rst_n == RST_ENABLE) begin
            rdata1 = '0;
        end else if (re1 != READ_ENABLE) begin
            rdata1 = '0;
        end else if (raddr1 == '0) begin
            rdata1 = '0;
        end else if (wb_wreg == WRITE_ENABLE && wb_wd == raddr1) begin
            rdata1 = wb_wdata;
        end
    end

    // Read port 2: same priority as port 1, fully independent.
    always_comb begin
        rdata2 = gpr[raddr2];
        if (cpu_rst_n == RST_ENABLE) begin
            rdata2 = '0;
        end else if (re2 != READ_ENABLE) begin
            rdata2 = '0;
        end else if (raddr2 == '0) begin
            rdata2 = '0;
        end else if (wb_wreg == WRITE_ENABLE && wb_wd == raddr2) begin
            rdata2 = wb_wdata;
        end
    end

    hilo_reg #(
        .DATA_W (DATA_W)
    ) u_hilo_reg (
        .cpu_clk_75M (cpu_clk_75M),
        .cpu_rst_n   (cpu_rst_n),
        .wb_whilo    (wb_whilo),
        .wb_hi       (wb_hi),
        .wb_lo       (wb_lo),
        .hi_o        (hi_o),
        .lo_o        (lo_o)
    );

endmodule : wb_regfile_hilo

// File: tb/tb_wb_regfile_hilo.sv
// ----------------------------------------------------------------------------
// tb_wb_regfile_hilo
// Self-checking bench for wb_regfile_hilo. A reference model of the GPR file
// and HI/LO pair produces the expected read-port values for every driven
// cycle; they are queued and compared against the DUT outputs just before
// the next rising edge.
// ----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_wb_regfile_hilo;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 5;
    localparam int NREG   = 32;

    // ---------------- clock / reset ----------------
    logic cpu_clk_75M;
    logic cpu_rst_n;

    initial cpu_clk_75M = 1'b0;
    always #5 cpu_clk_75M = ~cpu_clk_75M;

    // ---------------- DUT signals ----------------
    logic [ADDR_W-1:0] wb_wd;
    logic              wb_wreg;
    logic [DATA_W-1:0] wb_wdata;
    logic              wb_whilo;
    logic [DATA_W-1:0] wb_hi;
    logic [DATA_W-1:0] wb_lo;
    logic              re1;
    logic [ADDR_W-1:0] raddr1;
    logic              re2;
    logic [ADDR_W-1:0] raddr2;
    logic [DATA_W-1:0] rdata1;
    logic [DATA_W-1:0] rdata2;
    logic [DATA_W-1:0] hi_o;
    logic [DATA_W-1:0] lo_o;

    wb_regfile_hilo #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) dut (
        .cpu_clk_75M (cpu_clk_75M),
        .cpu_rst_n   (cpu_rst_n),
        .wb_wd       (wb_wd),
        .wb_wreg     (wb_wreg),
        .wb_wdata    (wb_wdata),
        .wb_whilo    (wb_whilo),
        .wb_hi       (wb_hi),
        .wb_lo       (wb_lo),
        .re1         (re1),
        .raddr1      (raddr1),
        .re2         (re2),
        .raddr2      (raddr2),
        .rdata1      (rdata1),
        .rdata2      (rdata2),
        .hi_o        (hi_o),
        .lo_o        (lo_o)
    );

    // ---------------- scoreboard ----------------
    logic [DATA_W-1:0] exp_q[$];
    string             tag_q[$];
    int                checks;
    int                failures;

    logic [DATA_W-1:0] m_gpr [NREG];
    logic [DATA_W-1:0] m_hi;
    logic [DATA_W-1:0] m_lo;
    string             phase;

    task automatic check(input string tag, input logic [DATA_W-1:0] obs,
                         input logic [DATA_W-1:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s/%s: got 0x%08h expected 0x%08h", phase, tag, obs, exp);
        end
    endtask

    task automatic model_clear();
        for (int i = 0; i < NREG; i++) m_gpr[i] = '0;
        m_hi = '0;
        m_lo = '0;
    endtask

    function automatic logic [DATA_W-1:0] model_read(input logic re,
                                                     input logic [ADDR_W-1:0] a);
        if (!cpu_rst_n)                 return '0;
        if (!re)                        return '0;
        if (a == '0)                    return '0;
        if (wb_wreg && wb_wd == a)      return wb_wdata;
        return m_gpr[a];
    endfunction

    task automatic push_expected();
        exp_q.push_back(model_read(re1, raddr1)); tag_q.push_back("rdata1");
        exp_q.push_back(model_read(re2, raddr2)); tag_q.push_back("rdata2");
        exp_q.push_back(!cpu_rst_n ? '0 : (wb_whilo ? wb_hi : m_hi)); tag_q.push_back("hi_o");
        exp_q.push_back(!cpu_rst_n ? '0 : (wb_whilo ? wb_lo : m_lo)); tag_q.push_back("lo_o");
    endtask

    task automatic pop_check(input logic [DATA_W-1:0] obs);
        if (exp_q.size() == 0) begin
            check("sb_underflow", DATA_W'(exp_q.size()), 1);
        end else begin
            check(tag_q.pop_front(), obs, exp_q.pop_front());
        end
    endtask

    task automatic compare_outputs();
        #1;
        pop_check(rdata1);
        pop_check(rdata2);
        pop_check(hi_o);
        pop_check(lo_o);
    endtask

    // ---------------- driver tasks ----------------
    task automatic drive(input logic [ADDR_W-1:0] wd, input logic wreg,
                         input logic [DATA_W-1:0] wdata, input logic whilo,
                         input logic [DATA_W-1:0] hi, input logic [DATA_W-1:0] lo,
                         input logic r1, input logic [ADDR_W-1:0] a1,
                         input logic r2, input logic [ADDR_W-1:0] a2);
        wb_wd = wd; wb_wreg = wreg; wb_wdata = wdata;
        wb_whilo = whilo; wb_hi = hi; wb_lo = lo;
        re1 = r1; raddr1 = a1; re2 = r2; raddr2 = a2;
    endtask

    // Called at a falling edge with inputs already driven: check the
    // combinational view, take the rising edge, then advance the model.
    task automatic run_cycle();
        push_expected();
        compare_outputs();
        @(posedge cpu_clk_75M);
        if (cpu_rst_n) begin
            if (wb_wreg && wb_wd != '0) m_gpr[wb_wd] = wb_wdata;
            if (wb_whilo) begin
                m_hi = wb_hi;
                m_lo = wb_lo;
            end
        end
        @(negedge cpu_clk_75M);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        checks   = 0;
        failures = 0;
        phase    = "reset";
        model_clear();
        cpu_rst_n = 1'b0;
        drive(5'd9, 1'b1, 32'h1111_2222, 1'b1, 32'h3333_4444, 32'h5555_6666,
              1'b1, 5'd9, 1'b1, 5'd9);
        #12;
        push_expected();
        compare_outputs();
        @(negedge cpu_clk_75M);
        drive('0, 1'b0, '0, 1'b0, '0, '0, 1'b0, '0, 1'b0, '0);
        cpu_rst_n = 1'b1;
        @(negedge cpu_clk_75M);

        phase = "write_readback";
        drive(5'd5, 1'b1, 32'hDEAD_BEEF, 1'b0, '0, '0, 1'b1, 5'd5, 1'b1, 5'd6);
        run_cycle();
        drive('0, 1'b0, '0, 1'b0, '0, '0, 1'b1, 5'd5, 1'b1, 5'd5);
        run_cycle();

        phase = "bypass";
        drive(5'd7, 1'b1, 32'h1234_5678, 1'b0, '0, '0, 1'b1, 5'd7, 1'b1, 5'd7);
        run_cycle();
        drive('0, 1'b0, '0, 1'b0, '0, '0, 1'b1, 5'd7, 1'b1, 5'd5);
        run_cycle();

        phase = "zero_protect";
        drive(5'd0, 1'b1, 32'hFFFF_FFFF, 1'b0, '0, '0, 1'b1, 5'd0, 1'b1, 5'd0);
        run_cycle();
        drive('0, 1'b0, '0, 1'b0, '0, '0, 1'b1, 5'd0, 1'b1, 5'd0);
        run_cycle();

        phase = "read_enable";
        drive(5'd5, 1'b1, 32'hCAFE_0001, 1'b0, '0, '0, 1'b1, 5'd7, 1'b0, 5'd5);
        run_cycle();
        drive('0, 1'b0, 32'hFFFF_0000, 1'b0, 32'h0BAD_0BAD, 32'h0BAD_0BAD,
              1'b1, 5'd5, 1'b1, 5'd7);
        run_cycle();

        phase = "hilo";
        drive('0, 1'b0, '0, 1'b1, 32'hA5A5_A5A5, 32'h5A5A_5A5A, 1'b0, '0, 1'b0, '0);
        run_cycle();
        drive('0, 1'b0, '0, 1'b0, 32'h1234_0000, 32'h0000_4321, 1'b1, 5'd5, 1'b1, 5'd7);
        run_cycle();
        run_cycle();

        phase = "random";
        for (int n = 0; n < 80; n++) begin
            logic [ADDR_W-1:0] wd;
            wd = ADDR_W'($urandom_range(0, NREG - 1));
            drive(wd, 1'($urandom_range(0, 1)), $urandom,
                  ($urandom_range(0, 3) == 0), $urandom, $urandom,
                  ($urandom_range(0, 3) != 0),
                  ($urandom_range(0, 2) == 0) ? wd : ADDR_W'($urandom_range(0, NREG - 1)),
                  ($urandom_range(0, 3) != 0),
                  ($urandom_range(0, 2) == 0) ? wd : ADDR_W'($urandom_range(0, NREG - 1)));
            run_cycle();
        end

        // Reset asserted away from any edge with a write pending: the write
        // is lost and every index must read zero while reset is held.
        phase = "mid_reset";
        drive(5'd3, 1'b1, 32'h3333_3333, 1'b1, 32'hEEEE_EEEE, 32'hDDDD_DDDD,
              1'b1, 5'd3, 1'b1, 5'd3);
        #2;
        cpu_rst_n = 1'b0;
        model_clear();
        for (int a = 0; a < NREG; a++) begin
            raddr1 = ADDR_W'(a);
            raddr2 = ADDR_W'(NREG - 1 - a);
            push_expected();
            compare_outputs();
        end
        @(negedge cpu_clk_75M);
        drive('0, 1'b0, '0, 1'b0, '0, '0, 1'b1, 5'd3, 1'b1, 5'd5);
        cpu_rst_n = 1'b1;

        phase = "after_reset";
        run_cycle();
        drive('0, 1'b0, '0, 1'b0, '0, '0, 1'b1, 5'd7, 1'b1, 5'd31);
        run_cycle();

        phase = "final";
        check("sb_drained", DATA_W'(exp_q.size()), '0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_wb_regfile_hilo
